// File: rtl/riscv_csr_unit_if.sv
// CSR access, trap and mret signals between the core pipeline (master) and the CSR unit (slave).
// The CSR unit has no ready. csr_en/trap_en/mret_en/instret_en each mean "happens this cycle" and are always accepted, and csr_rdata/csr_illegal answer in the same cycle.
interface riscv_csr_unit_if;
    logic        csr_en;
    logic [1:0]  csr_op;
    logic [11:0] csr_addr;
    logic [31:0] csr_wdata;
    logic        trap_en;
    logic [31:0] trap_cause;
    logic [31:0] trap_pc;
    logic        mret_en;
    logic        instret_en;
    logic [31:0] csr_rdata;
    logic        csr_illegal;
    logic [31:0] trap_vector;
    logic [31:0] mret_pc;

    modport master (
        output csr_en, csr_op, csr_addr, csr_wdata,
        output trap_en, trap_cause, trap_pc, mret_en, instret_en,
        input  csr_rdata, csr_illegal, trap_vector, mret_pc
    );

    modport slave (
        input  csr_en, csr_op, csr_addr, csr_wdata,
        input  trap_en, trap_cause, trap_pc, mret_en, instret_en,
        output csr_rdata, csr_illegal, trap_vector, mret_pc
    );
endinterface

// File: rtl/riscv_csr_unit.sv
// Machine-mode CSR file: Zicsr RW/RS/RC, trap entry and mret sequencing.
// Define RISCV_CSR_COUNTERS_EN to add the 64-bit mcycle/minstret counters and their read-only shadows.
module riscv_csr_unit #(
    parameter int          WORD_LENGTH = 32,
    parameter logic [31:0] HART_ID     = 32'd0,
    parameter logic [31:0] MTVEC_RESET = 32'h0000_0000
) (
    input logic             clk,
    input logic             rst,
    riscv_csr_unit_if.slave csr
);
    localparam logic [11:0] A_MSTATUS  = 12'h300;
    localparam logic [11:0] A_MTVEC    = 12'h305;
    localparam logic [11:0] A_MSCRATCH = 12'h340;
    localparam logic [11:0] A_MEPC     = 12'h341;
    localparam logic [11:0] A_MCAUSE   = 12'h342;
    localparam logic [11:0] A_MTVAL    = 12'h343;
    localparam logic [11:0] A_MHARTID  = 12'hF14;
`ifdef RISCV_CSR_COUNTERS_EN
    localparam logic [11:0] A_MCYCLE    = 12'hB00;
    localparam logic [11:0] A_MCYCLEH   = 12'hB80;
    localparam logic [11:0] A_MINSTRET  = 12'hB02;
    localparam logic [11:0] A_MINSTRETH = 12'hB82;
    localparam logic [11:0] A_CYCLE     = 12'hC00;
    localparam logic [11:0] A_CYCLEH    = 12'hC80;
    localparam logic [11:0] A_INSTRET   = 12'hC02;
    localparam logic [11:0] A_INSTRETH  = 12'hC82;
`endif

    logic [WORD_LENGTH-1:0] mtvec, mscratch, mepc, mcause;
    logic                   mie, mpie;

    logic [WORD_LENGTH-1:0] rdata, new_val;
    logic                   implemented, wr_effective, read_only, illegal, do_write;

`ifdef RISCV_CSR_COUNTERS_EN
    logic [63:0] mcycle, minstret;
`endif

    always_comb begin
        implemented = 1'b1;
        rdata       = '0;
        case (csr.csr_addr)
            A_MSTATUS:  rdata = {19'b0, 2'b11, 3'b0, mpie, 3'b0, mie, 3'b0};
            A_MTVEC:    rdata = mtvec;
            A_MSCRATCH: rdata = mscratch;
            A_MEPC:     rdata = mepc;
            A_MCAUSE:   rdata = mcause;
            A_MTVAL:    rdata = '0;
            A_MHARTID:  rdata = HART_ID;
`ifdef RISCV_CSR_COUNTERS_EN
            A_MCYCLE,   A_CYCLE:    rdata = mcycle[31:0];
            A_MCYCLEH,  A_CYCLEH:   rdata = mcycle[63:32];
            A_MINSTRET, A_INSTRET:  rdata = minstret[31:0];
            A_MINSTRETH, A_INSTRETH: rdata = minstret[63:32];
`endif
            default:    implemented = 1'b0;
        endcase
    end

    // RS/RC with a zero mask are pure reads, so they may target read-only CSRs.
    always_comb begin
        wr_effective = (csr.csr_op == 2'b01) || (csr.csr_op[1] && (csr.csr_wdata != '0));
        read_only    = (csr.csr_addr[11:10] == 2'b11);
        illegal      = csr.csr_en && (!implemented || (read_only && wr_effective));
        do_write     = csr.csr_en && wr_effective && !illegal && !csr.trap_en && !csr.mret_en;
        case (csr.csr_op)
            2'b01:   new_val = csr.csr_wdata;
            2'b10:   new_val = rdata | csr.csr_wdata;
            2'b11:   new_val = rdata & ~csr.csr_wdata;
            default: new_val = rdata;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mtvec    <= MTVEC_RESET & ~32'h3;
            mscratch <= '0;
            mepc     <= '0;
            mcause   <= '0;
            mie      <= 1'b0;
            mpie     <= 1'b0;
        end else if (csr.trap_en) begin
            mepc   <= csr.trap_pc & ~32'h3;
            mcause <= csr.trap_cause;
            mpie   <= mie;
            mie    <= 1'b0;
        end else if (csr.mret_en) begin
            mie  <= mpie;
            mpie <= 1'b1;
        end else if (do_write) begin
            case (csr.csr_addr)
                A_MSTATUS: begin
                    mie  <= new_val[3];
                    mpie <= new_val[7];
                end
                A_MTVEC:    mtvec    <= new_val & ~32'h3;
                A_MSCRATCH: mscratch <= new_val;
                A_MEPC:     mepc     <= new_val & ~32'h3;
                A_MCAUSE:   mcause   <= new_val;
                default:    ;
            endcase
        end
    end

`ifdef RISCV_CSR_COUNTERS_EN
    // A write to either half replaces that half and holds the whole counter for the cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mcycle   <= '0;
            minstret <= '0;
        end else begin
            if (do_write && csr.csr_addr == A_MCYCLE)
                mcycle <= {mcycle[63:32], new_val};
            else if (do_write && csr.csr_addr == A_MCYCLEH)
                mcycle <= {new_val, mcycle[31:0]};
            else
                mcycle <= mcycle + 64'd1;

            if (do_write && csr.csr_addr == A_MINSTRET)
                minstret <= {minstret[63:32], new_val};
            else if (do_write && csr.csr_addr == A_MINSTRETH)
                minstret <= {new_val, minstret[31:0]};
            else if (csr.instret_en)
                minstret <= minstret + 64'd1;
        end
    end
`else
    logic unused_instret;
    assign unused_instret = csr.instret_en;
`endif

    assign csr.csr_rdata   = rdata;
    assign csr.csr_illegal = illegal;
    assign csr.trap_vector = mtvec;
    assign csr.mret_pc     = mepc;
endmodule

// File: tb/tb_riscv_csr_unit.sv
// Directed and random checks of riscv_csr_unit against a CSR-level reference model.
module tb_riscv_csr_unit;
  localparam logic [31:0] HART      = 32'd5;
  localparam logic [31:0] MTVEC_RST = 32'h0000_1003;

  logic clk;
  logic rst;
  int   n_assert;
  int   n_fail;

  riscv_csr_unit_if bus ();

  riscv_csr_unit #(
    .WORD_LENGTH(32),
    .HART_ID(HART),
    .MTVEC_RESET(MTVEC_RST)
  ) dut (
    .clk(clk),
    .rst(rst),
    .csr(bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: plain CSRs by address, mstatus as two bits, counters as 64-bit numbers.
  logic [31:0] m_csr[int];
  bit          m_mie;
  bit          m_mpie;
  logic [63:0] m_cycle;
  logic [63:0] m_instret;

  logic [31:0] obs_rdata;
  logic        obs_illegal;

  function automatic bit model_impl(input logic [11:0] a);
`ifdef RISCV_CSR_COUNTERS_EN
    if (a inside {12'hB00, 12'hB80, 12'hB02, 12'hB82, 12'hC00, 12'hC80, 12'hC02, 12'hC82}) return 1'b1;
`endif
    return a inside {12'h300, 12'h305, 12'h340, 12'h341, 12'h342, 12'h343, 12'hF14};
  endfunction

  function automatic logic [31:0] model_read(input logic [11:0] a);
    case (a)
      12'h300: return 32'h0000_1800 + (m_mie ? 32'd8 : 32'd0) + (m_mpie ? 32'd128 : 32'd0);
      12'h305, 12'h340, 12'h341, 12'h342: return m_csr[int'(a)];
      12'hF14: return HART;
`ifdef RISCV_CSR_COUNTERS_EN
      12'hB00, 12'hC00: return m_cycle[31:0];
      12'hB80, 12'hC80: return m_cycle[63:32];
      12'hB02, 12'hC02: return m_instret[31:0];
      12'hB82, 12'hC82: return m_instret[63:32];
`endif
      default: return 32'd0;
    endcase
  endfunction

  task automatic model_reset();
    m_csr[int'(12'h305)] = MTVEC_RST & ~32'h3;
    m_csr[int'(12'h340)] = 32'd0;
    m_csr[int'(12'h341)] = 32'd0;
    m_csr[int'(12'h342)] = 32'd0;
    m_mie     = 1'b0;
    m_mpie    = 1'b0;
    m_cycle   = 64'd0;
    m_instret = 64'd0;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.csr_en     = 1'b0;
    bus.csr_op     = 2'b00;
    bus.csr_addr   = 12'h000;
    bus.csr_wdata  = 32'd0;
    bus.trap_en    = 1'b0;
    bus.trap_cause = 32'd0;
    bus.trap_pc    = 32'd0;
    bus.mret_en    = 1'b0;
    bus.instret_en = 1'b0;
  endtask

  // Called just after a negedge: apply inputs, check outputs, advance the model across the next posedge.
  task automatic drive(input logic en, input logic [1:0] op, input logic [11:0] addr,
                       input logic [31:0] wd, input logic trap, input logic [31:0] cause,
                       input logic [31:0] pc, input logic mret, input logic inst);
    logic        eff;
    logic        exp_ill;
    logic [31:0] old;
    logic [31:0] nv;
    logic [63:0] cyc_n;
    logic [63:0] ins_n;
    bus.csr_en     = en;
    bus.csr_op     = op;
    bus.csr_addr   = addr;
    bus.csr_wdata  = wd;
    bus.trap_en    = trap;
    bus.trap_cause = cause;
    bus.trap_pc    = pc;
    bus.mret_en    = mret;
    bus.instret_en = inst;
    #1;
    old     = model_read(addr);
    eff     = (op == 2'b01) || (op != 2'b00 && op != 2'b01 && wd != 32'd0);
    exp_ill = en && (!model_impl(addr) || (addr[11:10] == 2'b11 && eff));
    obs_rdata   = bus.csr_rdata;
    obs_illegal = bus.csr_illegal;
    check("csr_rdata", obs_rdata, old);
    check("csr_illegal", 32'(obs_illegal), 32'(exp_ill));
    check("trap_vector", bus.trap_vector, m_csr[int'(12'h305)]);
    check("mret_pc", bus.mret_pc, m_csr[int'(12'h341)]);

    case (op)
      2'b01:   nv = wd;
      2'b10:   nv = old | wd;
      2'b11:   nv = old & ~wd;
      default: nv = old;
    endcase
    cyc_n = m_cycle + 64'd1;
    ins_n = m_instret + (inst ? 64'd1 : 64'd0);
    if (trap) begin
      m_csr[int'(12'h341)] = pc & ~32'h3;
      m_csr[int'(12'h342)] = cause;
      m_mpie = m_mie;
      m_mie  = 1'b0;
    end else if (mret) begin
      m_mie  = m_mpie;
      m_mpie = 1'b1;
    end else if (en && eff && !exp_ill) begin
      case (addr)
        12'h300: begin
          m_mie  = nv[3];
          m_mpie = nv[7];
        end
        12'h305, 12'h341: m_csr[int'(addr)] = nv & ~32'h3;
        12'h340, 12'h342: m_csr[int'(addr)] = nv;
        12'hB00: cyc_n = {m_cycle[63:32], nv};
        12'hB80: cyc_n = {nv, m_cycle[31:0]};
        12'hB02: ins_n = {m_instret[63:32], nv};
        12'hB82: ins_n = {nv, m_instret[31:0]};
        default: ;
      endcase
    end
    m_cycle   = cyc_n;
    m_instret = ins_n;
    @(negedge clk);
  endtask

  task automatic rd(input logic [11:0] addr);
    drive(1'b1, 2'b00, addr, 32'd0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
  endtask

  task automatic wr(input logic [1:0] op, input logic [11:0] addr, input logic [31:0] wd);
    drive(1'b1, op, addr, wd, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
  endtask

  // Holds reset across a posedge, optionally with a write pending on the bus.
  task automatic do_reset(input bit with_write);
    if (with_write) begin
      bus.csr_en    = 1'b1;
      bus.csr_op    = 2'b01;
      bus.csr_addr  = 12'h340;
      bus.csr_wdata = 32'hDEAD_BEEF;
    end
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    idle_inputs();
    rst = 1'b0;
    model_reset();
  endtask

  logic [11:0] addr_pool[18];

  initial begin
    n_assert = 0;
    n_fail   = 0;
    rst      = 1'b1;
    idle_inputs();
    model_reset();
    addr_pool = '{12'h300, 12'h305, 12'h340, 12'h341, 12'h342, 12'h343, 12'hF14, 12'hB00, 12'hB80,
                  12'hB02, 12'hB82, 12'hC00, 12'hC80, 12'hC02, 12'hC82, 12'h301, 12'h7C0, 12'h000};
    @(negedge clk);
    do_reset(1'b0);

    // Reset values
    rd(12'h305); check("reset_mtvec", obs_rdata, 32'h0000_1000);
    check("reset_illegal", 32'(obs_illegal), 32'd0);
    rd(12'h300); check("reset_mstatus", obs_rdata, 32'h0000_1800);
    rd(12'h341); check("reset_mepc", obs_rdata, 32'd0);
    rd(12'h342); check("reset_mcause", obs_rdata, 32'd0);

    // RW / RS / RC on mscratch
    wr(2'b01, 12'h340, 32'hA5A5_0000); check("rw_old", obs_rdata, 32'd0);
    wr(2'b10, 12'h340, 32'h0000_000F); check("rs_old", obs_rdata, 32'hA5A5_0000);
    wr(2'b11, 12'h340, 32'hA000_0000); check("rc_old", obs_rdata, 32'hA5A5_000F);
    rd(12'h340); check("mscratch_final", obs_rdata, 32'h05A5_000F);

    // Trap entry and mret
    wr(2'b10, 12'h300, 32'h0000_0008);
    drive(1'b0, 2'b00, 12'h000, 32'd0, 1'b1, 32'd11, 32'h8000_0102, 1'b0, 1'b0);
    rd(12'h341); check("trap_mepc", obs_rdata, 32'h8000_0100);
    check("trap_mret_pc", bus.mret_pc, 32'h8000_0100);
    rd(12'h342); check("trap_mcause", obs_rdata, 32'd11);
    rd(12'h300); check("trap_mstatus", obs_rdata, 32'h0000_1880);
    drive(1'b0, 2'b00, 12'h000, 32'd0, 1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
    rd(12'h300); check("mret_mstatus", obs_rdata, 32'h0000_1888);

    // Trap wins over a same-cycle CSR write
    drive(1'b1, 2'b01, 12'h340, 32'h0000_1234, 1'b1, 32'd2, 32'h0000_0044, 1'b0, 1'b0);
    rd(12'h340); check("trap_drops_write", obs_rdata, 32'h05A5_000F);
    rd(12'h341); check("trap_prio_mepc", obs_rdata, 32'h0000_0044);

    // Read-only mhartid
    wr(2'b01, 12'hF14, 32'd1); check("ro_write_illegal", 32'(obs_illegal), 32'd1);
    wr(2'b10, 12'hF14, 32'd0); check("ro_pure_read_legal", 32'(obs_illegal), 32'd0);
    check("mhartid", obs_rdata, HART);

    // mtvec low bits are never stored
    wr(2'b01, 12'h305, 32'h0000_2003);
    rd(12'h305); check("mtvec_align", obs_rdata, 32'h0000_2000);

    // Counters
`ifdef RISCV_CSR_COUNTERS_EN
    wr(2'b01, 12'hB00, 32'hFFFF_FFFF);
    wr(2'b01, 12'hB80, 32'hFFFF_FFFF);
    rd(12'hB80); check("mcycle_hi_ones", obs_rdata, 32'hFFFF_FFFF);
    rd(12'hB00); check("mcycle_wrap_lo", obs_rdata, 32'd0);
    rd(12'hC80); check("cycle_wrap_hi", obs_rdata, 32'd0);
`else
    rd(12'hB00); check("no_counter_illegal", 32'(obs_illegal), 32'd1);
    check("no_counter_rdata", obs_rdata, 32'd0);
`endif

    // Reset while a write is pending on the bus
    do_reset(1'b1);
    rd(12'h340); check("reset_drops_write", obs_rdata, 32'd0);

    // Random traffic against the model
    for (int i = 0; i < 400; i++) begin
      logic [31:0] wd;
      wd = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
      drive(($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)), addr_pool[$urandom_range(0, 17)],
            wd, ($urandom_range(0, 15) == 0), $urandom, $urandom,
            ($urandom_range(0, 15) == 0), 1'($urandom_range(0, 1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
